// File: rtl/knn_vote.sv
// Majority-vote classifier: counts labels of the K nearest sorted entries and
// reports the winning class, ties resolved toward the class with the nearest member.
module knn_vote #(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = 16,
  parameter int unsigned TYPE_W    = 2,
  parameter int unsigned K         = 3,
  parameter int unsigned ASCENDING = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_sort,
  input  logic [N-1:0][W-1:0]          distance_array_sorted,
  input  logic [N-1:0][TYPE_W-1:0]     type_array_sorted,
  output logic [TYPE_W-1:0]            class_out,
  output logic [$clog2(K+1)-1:0]       vote_count,
  output logic [W-1:0]                 nearest_distance,
  output logic                         valid_class,
  output logic                         busy
);

  localparam int unsigned NUM_TYPES = 2 ** TYPE_W;
  localparam int unsigned CW        = $clog2(K + 1);
  localparam int unsigned RW        = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned IW        = (N > 1) ? $clog2(N) : 1;

  generate
    if (K < 1 || K > N) begin : g_bad_k
      $error("knn_vote: K must lie in 1..N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COUNT, SELECT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [N-1:0][W-1:0]         dist_q;
  logic [N-1:0][TYPE_W-1:0]    type_q;
  logic [CW-1:0]               cnt_q   [NUM_TYPES];
  logic [RW-1:0]               first_q [NUM_TYPES];
  logic [RW-1:0]               rank_q;
  logic [TYPE_W-1:0]           scan_q;
  logic [TYPE_W-1:0]           best_cls_q;
  logic [CW-1:0]               best_cnt_q;
  logic [RW-1:0]               best_first_q;
  logic [W-1:0]                near_q;

  logic [IW-1:0]               idx_c;
  logic [TYPE_W-1:0]           lbl_c;
  logic                        last_rank_c;
  logic                        last_scan_c;
  logic                        better_c;

  // Rank-to-index mapping and per-cycle decisions.
  always_comb begin
    if (ASCENDING != 0) idx_c = IW'(rank_q);
    else                idx_c = IW'(N - 1) - IW'(rank_q);
    lbl_c       = type_q[idx_c];
    last_rank_c = (rank_q == RW'(K - 1));
    last_scan_c = (scan_q == TYPE_W'(NUM_TYPES - 1));
    better_c    = (cnt_q[scan_q] > best_cnt_q) ||
                  ((cnt_q[scan_q] == best_cnt_q) && (cnt_q[scan_q] != '0) &&
                   (first_q[scan_q] < best_first_q));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_sort)  state_d = COUNT;
      COUNT:   if (last_rank_c) state_d = SELECT;
      SELECT:  if (last_scan_c) state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dist_q           <= '0;
      type_q           <= '0;
      for (int t = 0; t < NUM_TYPES; t++) begin
        cnt_q[t]   <= '0;
        first_q[t] <= '0;
      end
      rank_q           <= '0;
      scan_q           <= '0;
      best_cls_q       <= '0;
      best_cnt_q       <= '0;
      best_first_q     <= '0;
      near_q           <= '0;
      class_out        <= '0;
      vote_count       <= '0;
      nearest_distance <= '0;
      valid_class      <= 1'b0;
      busy             <= 1'b0;
    end else begin
      valid_class <= 1'b0;
      busy        <= (state_d != IDLE);
      case (state_q)
        IDLE: if (valid_sort) begin
          dist_q       <= distance_array_sorted;
          type_q       <= type_array_sorted;
          for (int t = 0; t < NUM_TYPES; t++) begin
            cnt_q[t]   <= '0;
            first_q[t] <= '0;
          end
          rank_q       <= '0;
          scan_q       <= '0;
          best_cls_q   <= '0;
          best_cnt_q   <= '0;
          best_first_q <= '0;
        end
        COUNT: begin
          // First rank seen for a label is kept for the nearest-member tie-break.
          if (cnt_q[lbl_c] == '0) first_q[lbl_c] <= rank_q;
          cnt_q[lbl_c] <= cnt_q[lbl_c] + CW'(1);
          if (rank_q == '0) near_q <= dist_q[idx_c];
          rank_q <= rank_q + RW'(1);
        end
        SELECT: begin
          if (better_c) begin
            best_cls_q   <= scan_q;
            best_cnt_q   <= cnt_q[scan_q];
            best_first_q <= first_q[scan_q];
          end
          scan_q <= scan_q + TYPE_W'(1);
        end
        DONE: begin
          class_out        <= best_cls_q;
          vote_count       <= best_cnt_q;
          nearest_distance <= near_q;
          valid_class      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Bench for knn_vote: three instances (default, descending order, K=N) driven by
// table vectors, hand sequences for busy/reset/back-to-back, and random vectors.
module tb_knn_vote;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int TW = 2;
  localparam int NT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0][W-1:0]  dist_in;
  logic [N-1:0][TW-1:0] typ_in;
  logic vs_a, vs_d, vs_k;

  logic [TW-1:0] cls_a, cls_d, cls_k;
  logic [1:0]    vc_a, vc_d;
  logic [3:0]    vc_k;
  logic [W-1:0]  nd_a, nd_d, nd_k;
  logic          val_a, val_d, val_k, busy_a, busy_d, busy_k;

  knn_vote #(.N(N), .W(W), .TYPE_W(TW), .K(3), .ASCENDING(1)) u_a (
    .clk(clk), .rst(rst), .valid_sort(vs_a), .distance_array_sorted(dist_in),
    .type_array_sorted(typ_in), .class_out(cls_a), .vote_count(vc_a),
    .nearest_distance(nd_a), .valid_class(val_a), .busy(busy_a));

  knn_vote #(.N(N), .W(W), .TYPE_W(TW), .K(3), .ASCENDING(0)) u_d (
    .clk(clk), .rst(rst), .valid_sort(vs_d), .distance_array_sorted(dist_in),
    .type_array_sorted(typ_in), .class_out(cls_d), .vote_count(vc_d),
    .nearest_distance(nd_d), .valid_class(val_d), .busy(busy_d));

  knn_vote #(.N(N), .W(W), .TYPE_W(TW), .K(8), .ASCENDING(1)) u_k (
    .clk(clk), .rst(rst), .valid_sort(vs_k), .distance_array_sorted(dist_in),
    .type_array_sorted(typ_in), .class_out(cls_k), .vote_count(vc_k),
    .nearest_distance(nd_k), .valid_class(val_k), .busy(busy_k));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int sel;
    int d[8];
    int t[8];
    int ec;
    int en;
    int enear;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: score each class as votes first, then closeness of its nearest member.
  function automatic void model(input int d[8], input int t[8], input int k, input int asc,
                                output int cls, output int cnt, output int near);
    int votes[NT];
    int firstr[NT];
    int best_score;
    for (int c = 0; c < NT; c++) begin
      votes[c]  = 0;
      firstr[c] = N;
    end
    for (int r = 0; r < k; r++) begin
      int lbl;
      lbl = t[asc ? r : N - 1 - r];
      if (r < firstr[lbl]) firstr[lbl] = r;
      votes[lbl]++;
    end
    best_score = -1;
    cls = 0;
    for (int c = 0; c < NT; c++) begin
      int s;
      s = (votes[c] > 0) ? votes[c] * (N + 1) + (N - firstr[c]) : 0;
      if (s > best_score) begin
        best_score = s;
        cls = c;
      end
    end
    cnt  = votes[cls];
    near = d[asc ? 0 : N - 1];
  endfunction

  task automatic load(input int d[8], input int t[8]);
    for (int i = 0; i < N; i++) begin
      dist_in[i] = W'(d[i]);
      typ_in[i]  = TW'(t[i]);
    end
  endtask

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0:       vs_a = v;
      1:       vs_d = v;
      default: vs_k = v;
    endcase
  endtask

  task automatic sample(input int sel, output int cls, output int cnt, output int near,
                        output int vc, output int bz);
    case (sel)
      0: begin cls = int'(cls_a); cnt = int'(vc_a); near = int'(nd_a); vc = int'(val_a); bz = int'(busy_a); end
      1: begin cls = int'(cls_d); cnt = int'(vc_d); near = int'(nd_d); vc = int'(val_d); bz = int'(busy_d); end
      default: begin cls = int'(cls_k); cnt = int'(vc_k); near = int'(nd_k); vc = int'(val_k); bz = int'(busy_k); end
    endcase
  endtask

  // Pulse valid_sort (caller sits on a negedge), wait for the result, check it.
  task automatic run(input int sel, input string nm, input int d[8], input int t[8],
                     input int ec, input int en, input int enear, input bit tail);
    int k, lat, cls, cnt, near, vc, bz;
    k = (sel == 2) ? 8 : 3;
    load(d, t);
    set_valid(sel, 1'b1);
    @(negedge clk);
    set_valid(sel, 1'b0);
    lat = 0;
    sample(sel, cls, cnt, near, vc, bz);
    while (vc == 0 && lat < 60) begin
      @(negedge clk);
      lat++;
      sample(sel, cls, cnt, near, vc, bz);
    end
    chk({nm, " latency"}, lat, k + NT + 1);
    if (vc != 0) begin
      chk({nm, " class_out"}, cls, ec);
      chk({nm, " vote_count"}, cnt, en);
      chk({nm, " nearest_distance"}, near, enear);
      chk({nm, " busy at valid"}, bz, 0);
    end
    if (tail) begin
      @(negedge clk);
      sample(sel, cls, cnt, near, vc, bz);
      chk({nm, " valid one cycle"}, vc, 0);
    end
  endtask

  vec_t tbl[7];

  initial begin
    int cls, cnt, near, vc, bz, pulses, pc, pn, pnear;
    int d[8];
    int t[8];
    int ec, en, enear;

    tbl[0] = '{0, '{1,2,3,4,5,6,7,8},        '{2,2,1,0,3,3,3,3}, 2, 2, 1};
    tbl[1] = '{0, '{5,6,7,8,9,10,11,12},     '{3,1,0,2,2,2,2,2}, 3, 1, 5};
    tbl[2] = '{0, '{10,20,30,40,50,60,70,80}, '{0,1,1,3,3,3,3,3}, 1, 2, 10};
    tbl[3] = '{0, '{3,3,4,9,9,9,9,9},        '{0,3,2,1,1,1,1,1}, 0, 1, 3};
    tbl[4] = '{0, '{7,7,7,7,7,7,7,7},        '{1,1,1,0,0,0,0,0}, 1, 3, 7};
    tbl[5] = '{1, '{8,7,6,5,4,3,2,1},        '{0,0,0,0,0,1,1,2}, 1, 2, 1};
    tbl[6] = '{1, '{9,9,9,9,9,9,9,2},        '{1,1,1,1,1,3,0,2}, 2, 1, 2};

    rst = 1'b0;
    vs_a = 1'b0; vs_d = 1'b0; vs_k = 1'b0;
    dist_in = '0; typ_in = '0;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sample(s, cls, cnt, near, vc, bz);
      chk($sformatf("reset dut%0d class_out", s), cls, 0);
      chk($sformatf("reset dut%0d vote_count", s), cnt, 0);
      chk($sformatf("reset dut%0d nearest", s), near, 0);
      chk($sformatf("reset dut%0d valid_class", s), vc, 0);
      chk($sformatf("reset dut%0d busy", s), bz, 0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run(tbl[i].sel, $sformatf("vec%0d", i), tbl[i].d, tbl[i].t, tbl[i].ec, tbl[i].en,
          tbl[i].enear, 1'b1);

    // Second pulse while busy is dropped; arrays changing mid-run have no effect.
    d = tbl[0].d; t = tbl[0].t;
    load(d, t);
    vs_a = 1'b1;
    @(negedge clk);
    vs_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy during run", int'(busy_a), 1);
    for (int i = 0; i < N; i++) begin
      t[i] = 3;
      d[i] = 100 + i;
    end
    load(d, t);
    vs_a = 1'b1;
    @(negedge clk);
    vs_a = 1'b0;
    pulses = 0; pc = -1; pn = -1; pnear = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (val_a) begin
        pulses++;
        pc = int'(cls_a); pn = int'(vc_a); pnear = int'(nd_a);
      end
    end
    chk("ignored pulse count", pulses, 1);
    chk("ignored pulse class", pc, 2);
    chk("ignored pulse votes", pn, 2);
    chk("ignored pulse nearest", pnear, 1);
    chk("busy after done", int'(busy_a), 0);

    // Reset during COUNT aborts the run.
    d = tbl[1].d; t = tbl[1].t;
    load(d, t);
    vs_a = 1'b1;
    @(negedge clk);
    vs_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    sample(0, cls, cnt, near, vc, bz);
    chk("abort class_out", cls, 0);
    chk("abort vote_count", cnt, 0);
    chk("abort nearest", near, 0);
    chk("abort busy", bz, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (val_a) pulses++;
    end
    chk("abort no valid_class", pulses, 0);
    run(0, "after abort", tbl[1].d, tbl[1].t, 3, 1, 5, 1'b1);

    // K=N, back-to-back acceptance on the cycle busy falls.
    for (int i = 0; i < N; i++) begin
      d[i] = 20 + i;
      t[i] = 1;
    end
    run(2, "k8 first", d, t, 1, 8, 20, 1'b0);
    d[0] = 4;
    run(2, "k8 back2back", d, t, 1, 8, 4, 1'b1);

    // Random vectors against the reference model.
    for (int it = 0; it < 30; it++) begin
      int sel;
      sel = it % 3;
      for (int i = 0; i < N; i++) begin
        d[i] = int'($urandom_range(0, 65535));
        t[i] = int'($urandom_range(0, NT - 1));
      end
      model(d, t, (sel == 2) ? 8 : 3, (sel == 1) ? 0 : 1, ec, en, enear);
      run(sel, $sformatf("rand%0d", it), d, t, ec, en, enear, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
